// File: rtl/coo_edge_loader.sv
// rtl/coo_edge_loader.sv - COO edge list loader: streams (row, col) pairs into the COO row/col memories
//
// Purpose:
//   Accepts edge pairs over a valid/ready handshake and writes them to
//   consecutive memory addresses 0..COO_EDGES-1. Once the whole list is
//   written, a level done flag tells the aggregation datapath it can walk
//   the edges. A new start from DONE reloads (overwrites) the list.
//
// Optional feature (macro COO_RANGE_CHECK_EN):
//   When defined, an accepted edge whose row or col is >= NUM_NODES is
//   consumed without being written, and the sticky err flag is set.
//   When undefined, every accepted edge is written and err is tied to 0.
//
// Ports:
//   clk         in   system clock, rising edge
//   reset       in   synchronous, active-high reset
//   start       in   begin a load session (honoured in IDLE or DONE)
//   edge_valid  in   edge_row/edge_col carry a valid edge
//   edge_ready  out  loader accepts an edge this cycle (registered)
//   edge_row    in   source node index
//   edge_col    in   destination node index
//   wr_en       out  memory write strobe, 1 cycle after the accept
//   wr_addr     out  memory write address
//   wr_row      out  row data to the COO row memory
//   wr_col      out  col data to the COO col memory
//   edge_count  out  edges written in the current session
//   done        out  full edge list loaded (level)
//   err         out  sticky out-of-range flag

module coo_edge_loader #(
    parameter int COO_EDGES = 6,
    parameter int COO_BW    = $clog2(COO_EDGES),
    parameter int NUM_NODES = 6,
    parameter int NODE_BW   = $clog2(NUM_NODES)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               edge_valid,
    output logic               edge_ready,
    input  logic [NODE_BW-1:0] edge_row,
    input  logic [NODE_BW-1:0] edge_col,
    output logic               wr_en,
    output logic [COO_BW-1:0]  wr_addr,
    output logic [NODE_BW-1:0] wr_row,
    output logic [NODE_BW-1:0] wr_col,
    output logic [COO_BW:0]    edge_count,
    output logic               done,
    output logic               err
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_LOAD = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [COO_BW-1:0] LAST_ADDR = COO_BW'(COO_EDGES - 1);

    logic [1:0]        state;
    logic [COO_BW-1:0] ptr;
    logic              accept;
    logic              in_range;

    // edge_ready is only ever high in LOAD, so accept implies LOAD.
    assign accept = edge_valid & edge_ready;

`ifdef COO_RANGE_CHECK_EN
    localparam logic [NODE_BW:0] NODE_LIM = (NODE_BW + 1)'(NUM_NODES);

    assign in_range = ({1'b0, edge_row} < NODE_LIM) && ({1'b0, edge_col} < NODE_LIM);

    // Sticky until reset or a new session starts.
    always_ff @(posedge clk) begin
        if (reset) begin
            err <= 1'b0;
        end else if (start && (state == S_IDLE || state == S_DONE)) begin
            err <= 1'b0;
        end else if (accept && !in_range) begin
            err <= 1'b1;
        end
    end
`else
    assign in_range = 1'b1;
    assign err      = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_IDLE;
            ptr        <= '0;
            edge_ready <= 1'b0;
            wr_en      <= 1'b0;
            wr_addr    <= '0;
            wr_row     <= '0;
            wr_col     <= '0;
            edge_count <= '0;
            done       <= 1'b0;
        end else begin
            // Strobe only in the cycle right after an accept; data holds.
            wr_en <= 1'b0;

            case (state)
                S_IDLE: begin
                    if (start) begin
                        state      <= S_LOAD;
                        edge_ready <= 1'b1;
                        ptr        <= '0;
                        edge_count <= '0;
                    end
                end

                S_LOAD: begin
                    // Out-of-range edges are consumed but leave ptr/count alone.
                    if (accept && in_range) begin
                        wr_en      <= 1'b1;
                        wr_addr    <= ptr;
                        wr_row     <= edge_row;
                        wr_col     <= edge_col;
                        edge_count <= edge_count + 1'b1;
                        if (ptr == LAST_ADDR) begin
                            ptr        <= '0;
                            state      <= S_DONE;
                            edge_ready <= 1'b0;
                        end else begin
                            ptr <= ptr + 1'b1;
                        end
                    end
                end

                S_DONE: begin
                    // done rises one cycle after entry, i.e. the cycle after
                    // the final write strobe, and drops right after a restart.
                    if (start) begin
                        state      <= S_LOAD;
                        edge_ready <= 1'b1;
                        done       <= 1'b0;
                        ptr        <= '0;
                        edge_count <= '0;
                    end else begin
                        done <= 1'b1;
                    end
                end

                default: begin
                    state      <= S_IDLE;
                    edge_ready <= 1'b0;
                    done       <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_coo_edge_loader.sv
// tb/tb_coo_edge_loader.sv - directed table-driven bench for coo_edge_loader

module tb_coo_edge_loader;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic       edge_valid;
    logic       edge_ready;
    logic [2:0] edge_row;
    logic [2:0] edge_col;
    logic       wr_en;
    logic [2:0] wr_addr;
    logic [2:0] wr_row;
    logic [2:0] wr_col;
    logic [3:0] edge_count;
    logic       done;
    logic       err;

    coo_edge_loader #(
        .COO_EDGES (6),
        .NUM_NODES (6)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .edge_valid (edge_valid),
        .edge_ready (edge_ready),
        .edge_row   (edge_row),
        .edge_col   (edge_col),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_row     (wr_row),
        .wr_col     (wr_col),
        .edge_count (edge_count),
        .done       (done),
        .err        (err)
    );

    always #5 clk = ~clk;

    // exp = {ready, wr_en, addr[2:0], row[2:0], col[2:0], count[3:0], done, err}
    typedef struct {
        bit          rst;
        bit          st;
        bit          v;
        logic [2:0]  r;
        logic [2:0]  c;
        logic [16:0] exp;
    } vec_t;

    vec_t vq[$];
    int   errors = 0;
    int   checks = 0;

    function automatic vec_t mk(bit rst, bit st, bit v, int r, int c,
                                bit rdy, bit we, int a, int er, int ec,
                                int cnt, bit dn, bit e);
        vec_t t;
        t.rst = rst;
        t.st  = st;
        t.v   = v;
        t.r   = 3'(r);
        t.c   = 3'(c);
        t.exp = {rdy, we, 3'(a), 3'(er), 3'(ec), 4'(cnt), dn, e};
        return t;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    logic [16:0] act_v;
    int          sent;
    int          nwr;
    bit          got_done;
    bit          acc;

    initial begin
        reset = 1'b1; start = 1'b0; edge_valid = 1'b0; edge_row = '0; edge_col = '0;

        //              rst st v  r  c | rdy we a row col cnt dn err
        // reset state, then basic back-to-back load
        vq.push_back(mk(1, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0));
        vq.push_back(mk(0, 1, 0, 0, 0,  1, 0, 0, 0, 0, 0, 0, 0));
        vq.push_back(mk(0, 0, 1, 0, 1,  1, 1, 0, 0, 1, 1, 0, 0));
        vq.push_back(mk(0, 0, 1, 1, 2,  1, 1, 1, 1, 2, 2, 0, 0));
        vq.push_back(mk(0, 0, 1, 2, 3,  1, 1, 2, 2, 3, 3, 0, 0));
        vq.push_back(mk(0, 0, 1, 3, 4,  1, 1, 3, 3, 4, 4, 0, 0));
        vq.push_back(mk(0, 0, 1, 4, 5,  1, 1, 4, 4, 5, 5, 0, 0));
        vq.push_back(mk(0, 0, 1, 5, 0,  0, 1, 5, 5, 0, 6, 0, 0));
        vq.push_back(mk(0, 0, 1, 5, 0,  0, 0, 5, 5, 0, 6, 1, 0));
        vq.push_back(mk(0, 0, 0, 0, 0,  0, 0, 5, 5, 0, 6, 1, 0));
        // reload with stalled source, start ignored mid-load
        vq.push_back(mk(0, 1, 0, 0, 0,  1, 0, 5, 5, 0, 0, 0, 0));
        vq.push_back(mk(0, 0, 1, 1, 0,  1, 1, 0, 1, 0, 1, 0, 0));
        vq.push_back(mk(0, 0, 0, 0, 0,  1, 0, 0, 1, 0, 1, 0, 0));
        vq.push_back(mk(0, 0, 0, 0, 0,  1, 0, 0, 1, 0, 1, 0, 0));
        vq.push_back(mk(0, 0, 1, 2, 1,  1, 1, 1, 2, 1, 2, 0, 0));
        vq.push_back(mk(0, 0, 0, 0, 0,  1, 0, 1, 2, 1, 2, 0, 0));
        vq.push_back(mk(0, 0, 1, 3, 2,  1, 1, 2, 3, 2, 3, 0, 0));
        vq.push_back(mk(0, 1, 0, 0, 0,  1, 0, 2, 3, 2, 3, 0, 0));
        vq.push_back(mk(0, 1, 1, 4, 3,  1, 1, 3, 4, 3, 4, 0, 0));
        vq.push_back(mk(0, 0, 1, 5, 4,  1, 1, 4, 5, 4, 5, 0, 0));
        vq.push_back(mk(0, 0, 1, 0, 5,  0, 1, 5, 0, 5, 6, 0, 0));
        vq.push_back(mk(0, 0, 0, 0, 0,  0, 0, 5, 0, 5, 6, 1, 0));
        // reset coincident with the 4th accept
        vq.push_back(mk(0, 1, 0, 0, 0,  1, 0, 5, 0, 5, 0, 0, 0));
        vq.push_back(mk(0, 0, 1, 1, 1,  1, 1, 0, 1, 1, 1, 0, 0));
        vq.push_back(mk(0, 0, 1, 2, 2,  1, 1, 1, 2, 2, 2, 0, 0));
        vq.push_back(mk(0, 0, 1, 3, 3,  1, 1, 2, 3, 3, 3, 0, 0));
        vq.push_back(mk(1, 0, 1, 4, 4,  0, 0, 0, 0, 0, 0, 0, 0));
        // idle: valid without start is never accepted
        vq.push_back(mk(0, 0, 1, 4, 4,  0, 0, 0, 0, 0, 0, 0, 0));
        vq.push_back(mk(0, 0, 1, 4, 4,  0, 0, 0, 0, 0, 0, 0, 0));
        // out-of-range edge (7,2) arriving at ptr=2
        vq.push_back(mk(0, 1, 0, 0, 0,  1, 0, 0, 0, 0, 0, 0, 0));
        vq.push_back(mk(0, 0, 1, 0, 1,  1, 1, 0, 0, 1, 1, 0, 0));
        vq.push_back(mk(0, 0, 1, 1, 2,  1, 1, 1, 1, 2, 2, 0, 0));
`ifdef COO_RANGE_CHECK_EN
        vq.push_back(mk(0, 0, 1, 7, 2,  1, 0, 1, 1, 2, 2, 0, 1));
        vq.push_back(mk(0, 0, 1, 2, 3,  1, 1, 2, 2, 3, 3, 0, 1));
`else
        vq.push_back(mk(0, 0, 1, 7, 2,  1, 1, 2, 7, 2, 3, 0, 0));
        vq.push_back(mk(0, 0, 1, 2, 3,  1, 1, 3, 2, 3, 4, 0, 0));
`endif

        @(negedge clk);
        for (int i = 0; i < vq.size(); i++) begin
            reset      = vq[i].rst;
            start      = vq[i].st;
            edge_valid = vq[i].v;
            edge_row   = vq[i].r;
            edge_col   = vq[i].c;
            @(posedge clk);
            @(negedge clk);
            act_v = {edge_ready, wr_en, wr_addr, wr_row, wr_col, edge_count, done, err};
            chk($sformatf("vec%0d", i), 32'(act_v), 32'(vq[i].exp));
        end

        // Irregular stall pattern: scoreboard every write against the send order.
        reset = 1'b1; start = 1'b0; edge_valid = 1'b0;
        @(posedge clk); @(negedge clk);
        reset = 1'b0; start = 1'b1;
        @(posedge clk); @(negedge clk);
        start    = 1'b0;
        sent     = 0;
        nwr      = 0;
        got_done = 1'b0;
        for (int cyc = 0; cyc < 60 && !got_done; cyc++) begin
            edge_valid = ((cyc % 3) == 0 || (cyc % 7) == 1) && (sent < 6);
            edge_row   = 3'(sent);
            edge_col   = 3'(5 - sent);
            acc        = edge_valid && edge_ready;
            @(posedge clk);
            @(negedge clk);
            if (acc) sent++;
            if (wr_en) begin
                chk($sformatf("stall_wr%0d", nwr), {23'd0, wr_addr, wr_row, wr_col},
                    {23'd0, 3'(nwr), 3'(nwr), 3'(5 - nwr)});
                nwr++;
            end
            if (done) got_done = 1'b1;
        end
        chk("stall_done_seen", 32'(got_done), 32'd1);
        chk("stall_write_total", 32'(nwr), 32'd6);
        chk("stall_edge_count", 32'(edge_count), 32'd6);
        chk("stall_ready_low", 32'(edge_ready), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/coo_edge_loader.md
Name: coo_edge_loader

Overview:
- Write side of the COO edge store that the GCN edge counter later walks.
- Accepts a stream of (row, col) edge pairs over a valid/ready handshake.
- Writes each pair into the COO row/col memories at consecutive addresses 0..COO_EDGES-1.
- Asserts a level done flag once the full edge list is loaded, so the aggregation datapath can start the edge traversal.

Parameters:
- COO_EDGES, 6, number of edges in the COO list.
- COO_BW, $clog2(COO_EDGES), edge address width.
- NUM_NODES, 6, number of graph nodes.
- NODE_BW, $clog2(NUM_NODES), node index width.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  begin a load session (sampled in IDLE or DONE only).
- edge_valid  input  1  edge_row/edge_col carry a valid edge.
- edge_ready  output  1  loader accepts an edge this cycle.
- edge_row  input  NODE_BW  source node index.
- edge_col  input  NODE_BW  destination node index.
- wr_en  output  1  memory write strobe.
- wr_addr  output  COO_BW  memory write address.
- wr_row  output  NODE_BW  row data to the COO row memory.
- wr_col  output  NODE_BW  col data to the COO col memory.
- edge_count  output  COO_BW+1  edges written in the current session.
- done  output  1  full edge list loaded (level).
- err  output  1  sticky out-of-range flag (optional feature only).

Behaviour:
- Clock and reset: single clock clk; reset is synchronous and active-high, sampled on rising clk only.
- Reset values: state=IDLE; edge_ready=0, wr_en=0, wr_addr=0, wr_row=0, wr_col=0, edge_count=0, done=0, err=0.
- FSM states: IDLE, LOAD, DONE.
- IDLE:
  - edge_ready=0.
  - start=1 -> LOAD; internal address ptr=0, edge_count=0.
- LOAD:
  - edge_ready=1 (registered, asserted from the first LOAD cycle).
  - Handshake: an edge is accepted when edge_valid & edge_ready. edge_valid without edge_ready is held by the source; the loader never drops an accepted edge.
  - Accepted edge, write timing: wr_en=1 on the next cycle, with wr_addr=ptr, wr_row=edge_row, wr_col=edge_col. Latency from accept to write is 1 cycle.
  - Accepted edge, bookkeeping: ptr increments and edge_count increments.
  - Back-to-back accepts sustain 1 write/cycle.
  - wr_en=0 in every cycle with no accept in the previous cycle. wr_addr/wr_row/wr_col hold their last values.
  - Accept with ptr==COO_EDGES-1: ptr wraps to 0, state -> DONE, edge_ready deasserts the following cycle (no extra edge accepted). The final write still issues 1 cycle later.
  - start while in LOAD: ignored.
- DONE:
  - done=1, edge_ready=0, edge_count=COO_EDGES held.
  - start=1 -> LOAD; done clears the next cycle, ptr=0, edge_count=0 (reload/overwrite).
- Simultaneous events:
  - reset has priority over start, accept and the pending write.
  - reset mid-LOAD discards any pending write (wr_en=0 next cycle) and returns to IDLE.
- Arithmetic: ptr is COO_BW bits and never exceeds COO_EDGES-1. edge_count is COO_BW+1 bits, range 0..COO_EDGES.
- Data passes through unmodified; no sign or width changes.

Optional Feature:
- Macro: COO_RANGE_CHECK_EN.
- Defined:
  - An accepted edge with edge_row>=NUM_NODES or edge_col>=NUM_NODES is consumed (handshake completes) but not written: no wr_en, ptr and edge_count unchanged.
  - err sets the next cycle and is sticky until reset or the next start.
  - Valid edges continue to load normally.
- Not defined: no range comparison logic; all accepted edges are written; err tied to 0.

Test Plan:
- Basic load: reset, start, 6 back-to-back edges (0,1),(1,2),(2,3),(3,4),(4,5),(5,0) -> wr_en for 6 consecutive cycles, each 1 cycle after its accept, wr_addr 0..5 with matching row/col; done=1 the cycle after the last write; edge_ready=0 after the 6th accept; edge_count=6.
- Stalled source: edge_valid toggles 1,0,0,1,... -> writes only on accepted edges, addresses contiguous 0..5, no duplicate or missing write, done after exactly 6 writes.
- Reload: from DONE, pulse start, load 6 new edges -> done drops the cycle after start, wr_addr restarts at 0, edge_count counts 0..6, done reasserts.
- Start ignored in LOAD and reset mid-load: start pulse after 3 accepts -> no restart, addresses continue at 3. Reset asserted the same cycle as the 4th accept -> no write for that edge, all outputs return to reset values, state IDLE.
- Idle behaviour: edge_valid=1 with no start -> edge_ready stays 0, no wr_en, done=0.
- COO_RANGE_CHECK_EN: edge (7,2) with NUM_NODES=6 accepted at ptr=2 -> no write, err=1 next cycle, next valid edge written at wr_addr=2. Without the macro, err stays 0 and (7,2) is written.
